// File: rtl/weave_row_gen.sv
// weave_row_gen -- weaving-draft row engine feeding the weaving01 pin mux.
//
// Holds a threading table (warp thread -> shaft) and a lift plan
// (row -> lifted shaft mask). Each output bit is set when its warp thread
// sits on a lifted shaft: out_row[i] = L[r][T[i]]. Rows stream out over a
// valid/ready handshake. The sequence either wraps to row 0 or stops after
// the last active row.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/sel/addr/data  table write port (sel 0 = threading, 1 = lift plan)
//   row_len, loop         sequence length (0 or >ROWS means ROWS) and wrap
//   start, stop           begin / abort a sequence
//   out_valid/ready       row handshake
//   out_row, out_row_idx  presented row and its index
//   busy                  high while a sequence is running
//   mirror                (WEAVE_MIRROR_EN only) bit-reverse loaded rows
//
// Optional feature macro: WEAVE_MIRROR_EN adds the mirror input.
// Reset defaults give a straight draw (T[i] = i mod 4) with a 2/2 twill
// lift plan (L[r] = 4'b0011 rotated left by r mod 4).

module weave_row_gen #(
    parameter int ROWS   = 8,
    parameter int SHAFTS = 4,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [2:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic [3:0]       row_len,
    input  logic             loop,
    input  logic             start,
    input  logic             stop,
`ifdef WEAVE_MIRROR_EN
    input  logic             mirror,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic [2:0]       out_row_idx,
    output logic             busy
);

    localparam int TW = (SHAFTS > 1) ? $clog2(SHAFTS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [3:0] ROWS_L = 4'(ROWS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [TW-1:0]      thread_tbl [WIDTH];
    logic [SHAFTS-1:0]  lift_tbl   [ROWS];
    logic [3:0]         row_cnt;       // captured effective row_len
    logic [3:0]         len_eff;
    logic               capture;
    logic               load;
    logic [2:0]         load_idx;
    logic               last;
    logic               accept;
    logic [SHAFTS-1:0]  lift_sel;
    logic [TW-1:0]      thr;
    logic [WIDTH-1:0]   row_calc;
    logic               unused_cfg;

    assign unused_cfg = &{1'b0, cfg_data};

    // 2/2 twill default: 0011 rotated left by r mod 4.
    function automatic logic [SHAFTS-1:0] twill(input int r);
        logic [7:0] d;
        d = 8'h33 << (r % 4);
        twill = '0;
        for (int s = 0; s < SHAFTS && s < 4; s++) twill[s] = d[4+s];
    endfunction

    assign len_eff = (row_len == 4'd0 || row_len > ROWS_L) ? ROWS_L : row_len;
    assign accept  = out_valid && out_ready;
    assign last    = ({1'b0, out_row_idx} == (row_cnt - 4'd1));
    assign busy    = (state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_idx  = out_row_idx;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    capture   = 1'b1;
                    load      = 1'b1;
                    load_idx  = 3'd0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    if (!last) begin
                        load     = 1'b1;
                        load_idx = out_row_idx + 3'd1;
                    end else if (loop) begin
                        load     = 1'b1;
                        load_idx = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Row built from the tables as they stand before the load edge, so a
    // write on the same edge only affects later rows.
    always_comb begin
        row_calc = '0;
        thr      = '0;
        lift_sel = lift_tbl[load_idx[RW-1:0]];
        for (int i = 0; i < WIDTH; i++) begin
`ifdef WEAVE_MIRROR_EN
            thr = mirror ? thread_tbl[WIDTH-1-i] : thread_tbl[i];
`else
            thr = thread_tbl[i];
`endif
            row_calc[i] = lift_sel[thr];
        end
    end

    // ---------------- datapath / tables ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= 3'd0;
            row_cnt     <= 4'd0;
            for (int i = 0; i < WIDTH; i++) thread_tbl[i] <= TW'(i % 4);
            for (int r = 0; r < ROWS; r++)  lift_tbl[r]   <= twill(r);
        end else begin
            if (cfg_we) begin
                if (!cfg_sel) thread_tbl[cfg_addr]        <= cfg_data[TW-1:0];
                else          lift_tbl[cfg_addr[RW-1:0]]  <= cfg_data[SHAFTS-1:0];
            end
            if (capture) row_cnt <= len_eff;
            if (load) begin
                out_row     <= row_calc;
                out_row_idx <= load_idx;
            end
            out_valid <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_weave_row_gen.sv
module tb_weave_row_gen;

    logic       clk = 0;
    logic       rst, cfg_we, cfg_sel, loop, start, stop, out_ready;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [3:0] row_len;
    logic       out_valid, busy;
    logic [7:0] out_row;
    logic [2:0] out_row_idx;
`ifdef WEAVE_MIRROR_EN
    logic       mirror = 1'b0;
`endif

    typedef struct {
        logic [7:0] row;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    weave_row_gen dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .row_len(row_len),
        .loop(loop), .start(start), .stop(stop),
`ifdef WEAVE_MIRROR_EN
        .mirror(mirror),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input logic [7:0] row, input logic [2:0] idx);
        exp_t x;
        x.row = row;
        x.idx = idx;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: every accepted row is compared against the scoreboard head.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_row: got row %0h idx %0d want none", out_row, out_row_idx);
            end else begin
                e = sb.pop_front();
                check("row", out_row, e.row);
                check("row_idx", out_row_idx, e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        rst = 1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
        row_len = 0; loop = 0; start = 0; stop = 0; out_ready = 1;
        repeat (2) step();
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_row", out_row, 0);
        check("rst_idx", out_row_idx, 0);
        check("rst_busy", busy, 0);
        step();
        rst = 0;

        // Default twill, full length, no loop.
        push(8'h33, 0); push(8'h66, 1); push(8'hCC, 2); push(8'h99, 3);
        push(8'h33, 4); push(8'h66, 5); push(8'hCC, 6); push(8'h99, 7);
        start = 1;
        step();
        start = 0;
        drain("t1_drain");
        @(negedge clk);
        check("t1_valid_end", out_valid, 0);
        check("t1_busy_end", busy, 0);

        // Backpressure on row 1, then stop alongside an accept.
        step();
        push(8'h33, 0); push(8'h66, 1);
        start = 1;
        step();
        start = 0;
        step();
        out_ready = 0;
        repeat (5) begin
            @(negedge clk);
            check("bp_row", out_row, 8'h66);
            check("bp_idx", out_row_idx, 1);
            check("bp_valid", out_valid, 1);
            step();
        end
        out_ready = 1;
        push(8'hCC, 2);
        step();
        stop = 1;
        step();
        stop = 0;
        @(negedge clk);
        check("stop_valid", out_valid, 0);
        check("stop_busy", busy, 0);
        check("stop_sb", sb.size(), 0);

        // Lift-plan write while row 0 is held.
        step();
        push(8'h33, 0); push(8'h11, 1);
        row_len = 2; loop = 0; out_ready = 0; start = 1;
        step();
        start = 0; cfg_we = 1; cfg_sel = 1; cfg_addr = 1; cfg_data = 8'h01;
        step();
        cfg_we = 0;
        @(negedge clk);
        check("wr_hold_row", out_row, 8'h33);
        check("wr_hold_idx", out_row_idx, 0);
        step();
        out_ready = 1;
        drain("t3_drain");
        step();
        cfg_we = 1; cfg_sel = 1; cfg_addr = 1; cfg_data = 8'h06;
        step();
        cfg_we = 0;

        // Loop wrap with row_len = 2, then stop.
        push(8'h33, 0); push(8'h66, 1); push(8'h33, 0); push(8'h66, 1); push(8'h33, 0);
        row_len = 2; loop = 1; out_ready = 1; start = 1;
        step();
        start = 0;
        repeat (4) step();
        stop = 1;
        step();
        stop = 0; loop = 0;
        @(negedge clk);
        check("loop_stop_valid", out_valid, 0);
        check("loop_stop_busy", busy, 0);
        check("loop_sb", sb.size(), 0);

        // Threading all on shaft 0.
        step();
        for (int i = 0; i < 8; i++) begin
            cfg_we = 1; cfg_sel = 0; cfg_addr = 3'(i); cfg_data = 8'h00;
            step();
        end
        cfg_we = 0;
        push(8'hFF, 0); push(8'h00, 1); push(8'h00, 2); push(8'hFF, 3);
        row_len = 4; loop = 0; start = 1;
        step();
        start = 0;
        drain("t5_drain");
        @(negedge clk);
        check("t5_valid_end", out_valid, 0);

        // Reset in the middle of a run restores tables and outputs.
        step();
        push(8'hFF, 0); push(8'h00, 1); push(8'h00, 2);
        row_len = 0; start = 1;
        step();
        start = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("mrst_valid", out_valid, 0);
        check("mrst_row", out_row, 0);
        check("mrst_idx", out_row_idx, 0);
        check("mrst_busy", busy, 0);
        check("mrst_sb", sb.size(), 0);
        step();
        push(8'h33, 0); push(8'h66, 1);
        row_len = 2; start = 1;
        step();
        start = 0;
        drain("t6_drain");
        @(negedge clk);
        check("t6_valid_end", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weave_row_gen.md
Name: weave_row_gen

Overview:
- Weaving-draft engine that produces the 8-bit pixel rows driven onto the weaving01 top-level output bus. It is the stage directly upstream of the pin mux.
- Holds a threading table (warp thread → shaft) and a lift plan (row → lifted shafts). Each output bit is 1 when its warp thread sits on a lifted shaft.
- Rows stream out over a valid/ready handshake, one row per accepted transfer. The sequence either repeats or stops after the last row.

Parameters:
- ROWS, 8, lift-plan depth; power of two, max 8.
- SHAFTS, 4, number of shafts; threading entries are log2(SHAFTS) bits wide.
- WIDTH, 8, number of warp threads, equal to the out_row width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  1  0 = threading table, 1 = lift plan.
- cfg_addr  in  3  entry index.
- cfg_data  in  8  write data: [1:0] used for threading, [3:0] used for lift plan.
- row_len  in  4  number of active rows; 0 or any value > ROWS is treated as ROWS.
- loop  in  1  1 = wrap to row 0 after the last row.
- start  in  1  begin a sequence.
- stop  in  1  abort the sequence.
- out_valid  out  1  out_row holds a valid row.
- out_ready  in  1  consumer accepts the row.
- out_row  out  8  woven row bits.
- out_row_idx  out  3  index of the row currently presented.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: only one clock and one reset exist: clk and a synchronous, active-high rst.
  - While rst is high at a clk edge: state = IDLE; out_valid = 0, out_row = 0, out_row_idx = 0, busy = 0.
  - Threading T[i] = i mod 4 (straight draw).
  - Lift plan L[r] = 4'b0011 rotated left by (r mod 4), which gives a 2/2 twill.
- Row function: out_row[i] = L[r][T[i]]. All bits are computed from table contents as they stood before the loading edge, then registered. No combinational path from inputs to outputs.
- Config writes:
  - Accepted in any state when cfg_we is high.
  - cfg_sel = 0: T[cfg_addr] = cfg_data[1:0].
  - cfg_sel = 1: L[cfg_addr mod ROWS] = cfg_data[3:0].
  - A write never alters a row already presented. It takes effect on the next row loaded after the write edge.
- FSM, states IDLE / RUN:
  - IDLE, start = 1 (and stop = 0): capture the effective row_len as N and enter RUN. Load row 0 on that same edge, so out_valid = 1 one cycle after start.
  - RUN, out_valid && out_ready, idx < N-1: load row idx+1 on the same edge (no bubble, one row per cycle at full throughput).
  - RUN, accept with idx == N-1:
    - loop = 1: load row 0.
    - loop = 0: go to IDLE; out_valid = 0 next cycle; out_row keeps its last value.
  - RUN, out_valid && !out_ready: out_row and out_row_idx hold stable. The same applies to loop and row_len changes during this time.
  - stop = 1 in any state: go to IDLE next cycle with out_valid = 0. stop beats start and beats a simultaneous accept.
  - start while busy is ignored. row_len changes are ignored until the next start.
- Precedence: rst > stop > accept/advance > start.

Optional Feature:
- Macro: WEAVE_MIRROR_EN.
- When defined:
  - Adds input port mirror (1 bit).
  - Each loaded row is bit-reversed (out_row[i] = L[r][T[WIDTH-1-i]]) while mirror is high.
  - mirror is sampled at the row-load edge, like the table contents.
- When undefined: no mirror port and no reversal; behaviour is exactly as above.

Test Plan:
- Reset defaults, row_len = 0, loop = 0, out_ready = 1, pulse start:
  - out_row sequence is 0x33, 0x66, 0xCC, 0x99, 0x33, 0x66, 0xCC, 0x99 on 8 consecutive cycles, with idx 0–7.
  - Then out_valid = 0 and busy = 0.
- Backpressure: hold out_ready = 0 for 5 cycles after row 1 → out_row stays at 0x66 and idx at 1 throughout; the row advances to 0xCC the cycle after ready rises.
- Lift-plan write while row 0 is held: write L[1] = 4'b0001 → row 0 stays 0x33; row 1 then reads 0x11.
- Loop wrap: row_len = 2, loop = 1, ready = 1 → 0x33, 0x66, 0x33, 0x66…; assert stop → out_valid = 0 and busy = 0 one cycle later.
- Threading write: set T[i] = 0 for all i, then start → row 0 = 0xFF, row 1 = 0x00, row 2 = 0x00, row 3 = 0xFF.
- Reset mid-sequence at row 2: all outputs go to 0 at the next edge, and the tables return to their defaults (the next run restarts at 0x33).
